slice_cfg_loader: RTL and testbench
===================================

# slice_cfg_loader

Configuration sequencer for one logic slice. Accepts a word-serial configuration stream from the fabric configuration bus over a valid/ready handshake and assembles it into a shadow register. It then drives the slice's parallel config bus, pulses the slice config enable for a programmable number of cycles, and finally releases the slice's register clock-enable for normal operation.

## Interface
- `TOTAL_BITS`, default 143: slice config width (4 LUTs × 33 + 2 mux-select bits + 1 carry-chain select + 8 FF-init bits).
- `W`, default 8: stream word width.
- `APPLY_CYCLES`, default 2: number of cycles `cen` is held high, ≥1.
- `NWORDS`, derived, = ceil(TOTAL_BITS/W) (18 at defaults).

Ports:
- `clk` in 1: single clock. All state is updated on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a load. Sampled only in IDLE, DONE and ERR.
- `in_data` in W: stream word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a word this cycle.
- `cfg_out` out TOTAL_BITS: registered parallel config bus to the slice.
- `cen` out 1: slice config enable.
- `reg_ce` out 1: slice register clock-enable.
- `busy` out 1: high in LOAD and APPLY.
- `done` out 1: configuration applied; the slice is running.
- `error` out 1: checksum mismatch. Exists only with the macro; tied 0 otherwise.

## Operation
- States: IDLE, LOAD, APPLY, DONE, ERR.
- IDLE
  - Outputs: `in_ready`=0, `cen`=0, `reg_ce`=0.
  - `start` → LOAD; the word counter clears to 0.
- LOAD
  - `in_ready`=1.
  - A word is accepted when `in_valid && in_ready`. Word k is written to shadow bits [k·W +: W], LSB-first.
  - Bits of the last word beyond TOTAL_BITS are discarded.
  - The counter increments per accepted word. Idle cycles (`in_valid`=0) leave all state unchanged.
  - When the final word is accepted → APPLY. The shadow is copied into `cfg_out` on the same edge.
- APPLY
  - `cen`=1 and `reg_ce`=0 for exactly APPLY_CYCLES cycles, counted by a down-counter; then → DONE.
  - `cfg_out` is stable for the whole time `cen` is high.
- DONE
  - `done`=1, `reg_ce`=1, `cen`=0. `cfg_out` is held.
  - `start` → LOAD: `done` and `reg_ce` drop; `cfg_out` holds its old value until the next APPLY.
- `start` in LOAD or APPLY is ignored. A load cannot be aborted except by `rst`.
- `in_valid` outside LOAD is ignored; no word is consumed.
- Reset values: state=IDLE; `cfg_out`=0, shadow=0, counters=0; `cen`=0, `reg_ce`=0, `in_ready`=0, `busy`=0, `done`=0, `error`=0.
- Reset mid-LOAD or mid-APPLY discards the partial load immediately; the slice is left unconfigured.

## Timing
- `in_ready` is high from the first cycle after `start` is sampled.
- Minimum load time: NWORDS cycles with back-to-back valid words.
- `cen` rises on the edge that accepts the final word (or the checksum word when the macro is enabled).
- `done` and `reg_ce` rise exactly APPLY_CYCLES cycles after `cen` rises, on the same edge where `cen` falls.
- Minimum `start`-to-`done` latency: 1 + NWORDS + APPLY_CYCLES cycles (21 at defaults, macro off).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SLICE_CFG_CHECKSUM_EN`.
- Defined:
  - LOAD accepts NWORDS+1 words. The extra word is a checksum chosen so that the sum of all NWORDS+1 words mod 2^W = 0.
  - If the check passes on acceptance of the checksum word → APPLY.
  - If it fails → ERR: `error`=1, no `cen` pulse, `cfg_out` unchanged, `reg_ce`=0.
  - In ERR, `start` clears `error` and → LOAD.
- Undefined:
  - Exactly NWORDS words are accepted.
  - The ERR state is not built; `error` is constant 0.

## Test plan
- Reset, `start`, then 18 back-to-back words 0x01..0x12 (macro off):
  - `cen` is high for 2 cycles starting 19 cycles after `start`.
  - `cfg_out[7:0]`=0x01, `cfg_out[142:136]`=0x12 & 0x7F.
  - `done`=1 at cycle 21.
- Same stream with `in_valid` deasserted every other cycle:
  - `in_ready` stays high and the resulting `cfg_out` is identical.
  - `cen` rises 36 cycles after `start`.
- `start` pulsed during LOAD after word 5, and again during APPLY:
  - Both are ignored; `cfg_out` and timing match the first scenario.
- `rst` asserted after word 10:
  - Next cycle all outputs are at reset values.
  - A fresh 18-word load completes normally with no residue from the first attempt.
- From DONE, `start` and load all-0xFF:
  - `done` and `reg_ce` drop the cycle after `start`.
  - `cfg_out` holds the old value until the new `cen`, then reads all ones.
- Macro on, words 0x01..0x12 followed by checksum 0x55 (correct value 0x55):
  - → APPLY.
  - Repeating with checksum 0x54 → `error`=1, no `cen`, `cfg_out` unchanged.

Source files
------------

// File: rtl/slice_cfg_loader.sv
// Slice configuration sequencer: word-serial stream -> shadow register -> cen pulse -> reg_ce release.
// Define SLICE_CFG_CHECKSUM_EN to require a trailing checksum word and build the ERR state.
module slice_cfg_loader #(
    parameter int TOTAL_BITS   = 143,
    parameter int W            = 8,
    parameter int APPLY_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [TOTAL_BITS-1:0] cfg_out,
    output logic                  cen,
    output logic                  reg_ce,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int NWORDS = (TOTAL_BITS + W - 1) / W;
`ifdef SLICE_CFG_CHECKSUM_EN
    localparam int NACCEPT = NWORDS + 1;
`else
    localparam int NACCEPT = NWORDS;
`endif
    localparam int CW = $clog2(NACCEPT + 1);
    localparam int AW = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_APPLY = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef SLICE_CFG_CHECKSUM_EN
    localparam logic [2:0] S_ERR   = 3'd4;
`endif

    localparam logic [CW-1:0] LAST_WORD  = CW'(NACCEPT - 1);
    localparam logic [AW-1:0] APPLY_LAST = AW'(APPLY_CYCLES - 1);

    logic [2:0]            state;
    logic [CW-1:0]         wcnt;
    logic [AW-1:0]         acnt;
    logic [TOTAL_BITS-1:0] shadow;
    logic [TOTAL_BITS-1:0] shadow_nxt;
    logic                  accept;
    logic                  last_word;
    logic                  restart;

    assign accept    = in_valid && in_ready;
    assign last_word = (wcnt == LAST_WORD);

    // Bit i belongs to word i/W; upper bits of the final word simply have no destination.
    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < TOTAL_BITS; i++) begin
            if (wcnt == CW'(i / W)) shadow_nxt[i] = in_data[i % W];
        end
    end

`ifdef SLICE_CFG_CHECKSUM_EN
    logic [W-1:0] csum;
    logic [W-1:0] csum_nxt;

    assign csum_nxt = csum + in_data;
    assign restart  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
`else
    assign restart  = start && (state == S_IDLE || state == S_DONE);
    assign error    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            acnt     <= '0;
            shadow   <= '0;
            cfg_out  <= '0;
            in_ready <= 1'b0;
            cen      <= 1'b0;
            reg_ce   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SLICE_CFG_CHECKSUM_EN
            csum     <= '0;
            error    <= 1'b0;
`endif
        end else if (restart) begin
            state    <= S_LOAD;
            wcnt     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            reg_ce   <= 1'b0;
`ifdef SLICE_CFG_CHECKSUM_EN
            csum     <= '0;
            error    <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        shadow <= shadow_nxt;
                        wcnt   <= wcnt + 1'b1;
`ifdef SLICE_CFG_CHECKSUM_EN
                        csum   <= csum_nxt;
                        if (last_word) begin
                            in_ready <= 1'b0;
                            if (csum_nxt == '0) begin
                                state   <= S_APPLY;
                                cfg_out <= shadow_nxt;
                                cen     <= 1'b1;
                                acnt    <= APPLY_LAST;
                            end else begin
                                // cfg_out keeps the last good configuration
                                state <= S_ERR;
                                busy  <= 1'b0;
                                error <= 1'b1;
                            end
                        end
`else
                        if (last_word) begin
                            in_ready <= 1'b0;
                            state    <= S_APPLY;
                            cfg_out  <= shadow_nxt;
                            cen      <= 1'b1;
                            acnt     <= APPLY_LAST;
                        end
`endif
                    end
                end
                S_APPLY: begin
                    if (acnt == '0) begin
                        state  <= S_DONE;
                        cen    <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        reg_ce <= 1'b1;
                    end else begin
                        acnt <= acnt - 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slice_cfg_loader.sv
// Self-checking bench for slice_cfg_loader; reference config/timing derived from the word list and valid pattern.
`timescale 1ns/1ps
module tb_slice_cfg_loader;
    localparam int TOTAL_BITS   = 143;
    localparam int W            = 8;
    localparam int APPLY_CYCLES = 2;
    localparam int NWORDS       = (TOTAL_BITS + W - 1) / W;
`ifdef SLICE_CFG_CHECKSUM_EN
    localparam int NACC = NWORDS + 1;
`else
    localparam int NACC = NWORDS;
`endif
    localparam int BUDGET = 200;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [W-1:0]          in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [TOTAL_BITS-1:0] cfg_out;
    logic                  cen;
    logic                  reg_ce;
    logic                  busy;
    logic                  done;
    logic                  error;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0]          words [NWORDS+1];
    logic [TOTAL_BITS-1:0] cur_cfg;

    typedef struct {
        int                    exp_cen;
        int                    obs_cen;
        int                    cen_len;
        int                    obs_done;
        logic [TOTAL_BITS-1:0] exp_cfg;
        logic [TOTAL_BITS-1:0] cfg_end;
        bit                    hold_bad;
        bit                    rdy_bad;
        bit                    first_ok;
        bit                    done_ok;
        bit                    err_seen;
    } run_t;

    slice_cfg_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cfg_out(cfg_out), .cen(cen), .reg_ce(reg_ce),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [TOTAL_BITS-1:0] model_cfg();
        logic [TOTAL_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < TOTAL_BITS; i++) c[i] = words[i / W][i % W];
        return c;
    endfunction

    function automatic logic [W-1:0] model_csum();
        int s;
        s = 0;
        for (int k = 0; k < NWORDS; k++) s += int'(words[k]);
        return W'((1 << W) - (s % (1 << W)));
    endfunction

    task automatic fill_words(input int kind);
        for (int k = 0; k < NWORDS; k++) begin
            case (kind)
                0:       words[k] = W'(k + 1);
                1:       words[k] = '1;
                default: words[k] = W'($urandom);
            endcase
        end
        words[NWORDS] = model_csum();
    endtask

    // mode 0: back-to-back, 1: valid on odd cycles only, 2: random valid with junk outside LOAD
    task automatic run_load(input int mode, input int ga, input int gb,
                            input logic [TOTAL_BITS-1:0] prev_cfg, output run_t r);
        int n;
        logic v;
        n = 0;
        r.exp_cen = -1; r.obs_cen = -1; r.cen_len = 0; r.obs_done = -1;
        r.exp_cfg = model_cfg(); r.cfg_end = '0;
        r.hold_bad = 0; r.rdy_bad = 0; r.done_ok = 0; r.err_seen = 0;
        start = 1'b1;
        in_valid = (mode == 2);
        in_data = 8'hA5;
        @(posedge clk); #1;
        start = 1'b0;
        r.first_ok = (in_ready === 1'b1) && (done === 1'b0) && (reg_ce === 1'b0) &&
                     (busy === 1'b1) && (cen === 1'b0) && (error === 1'b0);
        for (int t = 1; t <= BUDGET && r.obs_done < 0 && !r.err_seen; t++) begin
            case (mode)
                1:       v = t[0];
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            in_valid = (n < NACC || mode == 2) ? v : 1'b0;
            in_data  = (n < NACC) ? words[n] : W'($urandom);
            start    = (t == ga || t == gb);
            @(posedge clk); #1;
            if (in_valid && n < NACC) begin
                n++;
                if (n == NACC) r.exp_cen = t;
            end
            if (in_ready !== ((n < NACC) ? 1'b1 : 1'b0)) r.rdy_bad = 1;
            if (cen === 1'b1) begin
                if (r.obs_cen < 0) r.obs_cen = t;
                r.cen_len++;
                if (cfg_out !== r.exp_cfg) r.hold_bad = 1;
            end else if (r.obs_cen < 0 && cfg_out !== prev_cfg) begin
                r.hold_bad = 1;
            end
            if (done === 1'b1) begin
                r.obs_done = t;
                r.cfg_end  = cfg_out;
                r.done_ok  = (reg_ce === 1'b1) && (cen === 1'b0) && (busy === 1'b0);
            end
            if (error === 1'b1) r.err_seen = 1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, cen, reg_ce, busy, done, error} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {in_ready, cen, reg_ce, busy, done, error});
        end
        n_cmp++;
        if (cfg_out !== '0) begin
            n_fail++; $display("FAIL reset_cfg: got %h expected 0", cfg_out);
        end
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready, busy, cen} !== 3'b0) begin
            n_fail++; $display("FAIL idle_no_start: got %b expected 000", {in_ready, busy, cen});
        end
        cur_cfg = '0;
    endtask

    task automatic test_back_to_back();
        run_t r;
        fill_words(0);
        run_load(0, -1, -1, cur_cfg, r);
        n_cmp++;
        if (!r.first_ok) begin n_fail++; $display("FAIL b2b_first_cycle: got 0 expected 1"); end
        n_cmp++;
        if (r.obs_cen !== r.exp_cen) begin
            n_fail++; $display("FAIL b2b_cen_rise: got %0d expected %0d", r.obs_cen, r.exp_cen);
        end
        n_cmp++;
        if (r.cen_len !== APPLY_CYCLES) begin
            n_fail++; $display("FAIL b2b_cen_len: got %0d expected %0d", r.cen_len, APPLY_CYCLES);
        end
        n_cmp++;
        if (r.obs_done !== r.exp_cen + APPLY_CYCLES) begin
            n_fail++; $display("FAIL b2b_done: got %0d expected %0d", r.obs_done, r.exp_cen + APPLY_CYCLES);
        end
        n_cmp++;
        if (!r.done_ok) begin n_fail++; $display("FAIL b2b_done_outputs: got 0 expected 1"); end
        n_cmp++;
        if (r.cfg_end[7:0] !== 8'h01 || r.cfg_end[142:136] !== 7'h12) begin
            n_fail++; $display("FAIL b2b_cfg_ends: got %h/%h expected 01/12", r.cfg_end[7:0], r.cfg_end[142:136]);
        end
        n_cmp++;
        if (r.cfg_end !== r.exp_cfg) begin
            n_fail++; $display("FAIL b2b_cfg: got %h expected %h", r.cfg_end, r.exp_cfg);
        end
        n_cmp++;
        if (r.hold_bad || r.rdy_bad || r.err_seen) begin
            n_fail++; $display("FAIL b2b_flags: got %0d%0d%0d expected 000", r.hold_bad, r.rdy_bad, r.err_seen);
        end
        cur_cfg = r.exp_cfg;
    endtask

    task automatic test_gapped();
        run_t r;
        fill_words(0);
        run_load(1, -1, -1, cur_cfg, r);
        n_cmp++;
        if (r.rdy_bad) begin n_fail++; $display("FAIL gap_in_ready: got 1 expected 0"); end
        n_cmp++;
        if (r.obs_cen !== r.exp_cen) begin
            n_fail++; $display("FAIL gap_cen_rise: got %0d expected %0d", r.obs_cen, r.exp_cen);
        end
        n_cmp++;
        if (r.obs_done !== r.exp_cen + APPLY_CYCLES) begin
            n_fail++; $display("FAIL gap_done: got %0d expected %0d", r.obs_done, r.exp_cen + APPLY_CYCLES);
        end
        n_cmp++;
        if (r.cfg_end !== r.exp_cfg || r.hold_bad) begin
            n_fail++; $display("FAIL gap_cfg: got %h expected %h", r.cfg_end, r.exp_cfg);
        end
        cur_cfg = r.exp_cfg;
    endtask

    task automatic test_ignored_start();
        run_t r;
        fill_words(0);
        run_load(0, 6, NACC + 1, cur_cfg, r);
        n_cmp++;
        if (r.obs_cen !== r.exp_cen || r.cen_len !== APPLY_CYCLES) begin
            n_fail++; $display("FAIL ign_cen: got %0d/%0d expected %0d/%0d", r.obs_cen, r.cen_len, r.exp_cen, APPLY_CYCLES);
        end
        n_cmp++;
        if (r.obs_done !== r.exp_cen + APPLY_CYCLES) begin
            n_fail++; $display("FAIL ign_done: got %0d expected %0d", r.obs_done, r.exp_cen + APPLY_CYCLES);
        end
        n_cmp++;
        if (r.cfg_end !== r.exp_cfg || r.hold_bad || r.rdy_bad) begin
            n_fail++; $display("FAIL ign_cfg: got %h expected %h", r.cfg_end, r.exp_cfg);
        end
        cur_cfg = r.exp_cfg;
    endtask

    task automatic test_reset_mid_load();
        run_t r;
        fill_words(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = words[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, cen, reg_ce, busy, done, error} !== 6'b0 || cfg_out !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b cfg %h expected 000000 cfg 0", {in_ready, cen, reg_ce, busy, done, error}, cfg_out);
        end
        cur_cfg = '0;
        fill_words(2);
        run_load(0, -1, -1, cur_cfg, r);
        n_cmp++;
        if (r.obs_done !== r.exp_cen + APPLY_CYCLES || !r.first_ok) begin
            n_fail++; $display("FAIL midrst_reload_done: got %0d expected %0d", r.obs_done, r.exp_cen + APPLY_CYCLES);
        end
        n_cmp++;
        if (r.cfg_end !== r.exp_cfg || r.hold_bad) begin
            n_fail++; $display("FAIL midrst_reload_cfg: got %h expected %h", r.cfg_end, r.exp_cfg);
        end
        cur_cfg = r.exp_cfg;
    endtask

    task automatic test_reload_ones();
        run_t r;
        fill_words(1);
        run_load(0, -1, -1, cur_cfg, r);
        n_cmp++;
        if (!r.first_ok) begin n_fail++; $display("FAIL ones_done_drop: got 0 expected 1"); end
        n_cmp++;
        if (r.hold_bad) begin n_fail++; $display("FAIL ones_cfg_hold: got 1 expected 0"); end
        n_cmp++;
        if (r.cfg_end !== {TOTAL_BITS{1'b1}}) begin
            n_fail++; $display("FAIL ones_cfg: got %h expected all ones", r.cfg_end);
        end
        cur_cfg = r.exp_cfg;
    endtask

    task automatic test_random();
        run_t r;
        for (int it = 0; it < 4; it++) begin
            fill_words(2);
            run_load(2, -1, -1, cur_cfg, r);
            n_cmp++;
            if (r.obs_cen !== r.exp_cen || r.obs_done !== r.exp_cen + APPLY_CYCLES) begin
                n_fail++;
                $display("FAIL rand%0d_timing: got %0d/%0d expected %0d/%0d", it, r.obs_cen, r.obs_done, r.exp_cen, r.exp_cen + APPLY_CYCLES);
            end
            n_cmp++;
            if (r.cfg_end !== r.exp_cfg || r.hold_bad || r.rdy_bad) begin
                n_fail++; $display("FAIL rand%0d_cfg: got %h expected %h", it, r.cfg_end, r.exp_cfg);
            end
            cur_cfg = r.exp_cfg;
        end
    endtask

`ifdef SLICE_CFG_CHECKSUM_EN
    task automatic test_checksum();
        run_t r;
        bit   bad;
        fill_words(0);
        run_load(0, -1, -1, cur_cfg, r);
        n_cmp++;
        if (r.obs_done !== r.exp_cen + APPLY_CYCLES || r.cfg_end !== r.exp_cfg) begin
            n_fail++; $display("FAIL csum_good: got %0d expected %0d", r.obs_done, r.exp_cen + APPLY_CYCLES);
        end
        cur_cfg = r.exp_cfg;
        fill_words(2);
        words[NWORDS] = model_csum() - 1'b1;
        run_load(0, -1, -1, cur_cfg, r);
        n_cmp++;
        if (!r.err_seen || r.cen_len !== 0 || r.obs_done !== -1) begin
            n_fail++; $display("FAIL csum_bad: got err %0d cen %0d expected err 1 cen 0", r.err_seen, r.cen_len);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (cen !== 1'b0 || error !== 1'b1 || reg_ce !== 1'b0 || cfg_out !== cur_cfg) bad = 1;
        end
        n_cmp++;
        if (bad) begin n_fail++; $display("FAIL csum_err_hold: got 1 expected 0"); end
        fill_words(2);
        run_load(0, -1, -1, cur_cfg, r);
        n_cmp++;
        if (!r.first_ok || r.cfg_end !== r.exp_cfg) begin
            n_fail++; $display("FAIL csum_recover: got %h expected %h", r.cfg_end, r.exp_cfg);
        end
        cur_cfg = r.exp_cfg;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_ignored_start();
        test_reset_mid_load();
        test_reload_ones();
        test_random();
`ifdef SLICE_CFG_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
